tdes_key_sequencer: RTL and testbench

Control block for the two-key Triple-DES (EDE) engine. It holds the two 56-bit keys (K1, K2), supplied post-PC-1 as C||D, and sequences a single-round DES core through three 16-round passes (K1/K2/K1). For each pass it selects the direction and delivers the per-round rotated C||D state; the core applies PC-2 and the Feistel round. It sits between the key source and the round datapath and owns all scheduling. It does not carry block data.

---
 rtl/tdes_key_sequencer.sv | 95 +++++++++
 tb/tb_tdes_key_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tdes_key_sequencer.sv
// tdes_key_sequencer: sequences the K1/K2/K1 three-pass DES key schedule for a single-round core.
module tdes_key_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [55:0] key1,
  input  logic [55:0] key2,
  input  logic        key_load,
  input  logic        start,
  input  logic        mode,
  output logic        in_ready,
  output logic        core_init,
  output logic        round_en,
  output logic [55:0] round_cd,
  output logic [3:0]  round_idx,
  output logic [1:0]  pass_idx,
  output logic        pass_decrypt,
  output logic        pass_end,
  output logic        done,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, INIT, ROUND, PASS_END, DONE} state_t;
  state_t state, state_n;
  logic [55:0] k1, k2, key_n;
  logic keys_valid, mode_r, accept, dec_n;
  logic [1:0] pass_n;
  function automatic logic [1:0] sh(input logic [3:0] i);
    return (i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15) ? 2'd1 : 2'd2;
  endfunction
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic [1:0] n);
    return left ? (n == 2'd2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]})
                : (n == 2'd2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]});
  endfunction
  function automatic logic [55:0] rot(input logic [55:0] cd, input logic left, input logic [1:0] n);
    return {rot28(cd[55:28], left, n), rot28(cd[27:0], left, n)};
  endfunction
  assign in_ready  = state == IDLE && keys_valid;
  assign core_init = state == INIT;
  assign round_en  = state == ROUND;
  assign pass_end  = state == PASS_END;
  assign done      = state == DONE;
  assign busy      = state != IDLE;
  assign accept    = in_ready && start && !key_load;
  assign pass_n    = pass_idx + 2'd1;
  assign dec_n     = mode_r ^ (pass_n == 2'd1);
  assign key_n     = pass_n == 2'd1 ? k2 : k1;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = accept ? INIT : IDLE;
      INIT:     state_n = ROUND;
      ROUND:    state_n = round_idx == 4'd15 ? PASS_END : ROUND;
      PASS_END: state_n = pass_idx == 2'd2 ? DONE : ROUND;
      default:  state_n = IDLE;
    endcase
  end
  // An encrypt pass enters round 1 already rotated by one; a decrypt pass enters with the raw key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k1           <= '0;
      k2           <= '0;
      keys_valid   <= 1'b0;
      mode_r       <= 1'b0;
      round_cd     <= '0;
      round_idx    <= '0;
      pass_idx     <= '0;
      pass_decrypt <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && key_load) begin
        k1         <= key1;
        k2         <= key2;
        keys_valid <= 1'b1;
      end
      if (accept) mode_r <= mode;
      if (state == INIT) begin
        pass_idx     <= '0;
        round_idx    <= '0;
        pass_decrypt <= mode_r;
        round_cd     <= mode_r ? k1 : rot(k1, 1'b1, 2'd1);
      end
      if (state == ROUND) begin
        round_idx <= round_idx + 4'd1;
        round_cd  <= pass_decrypt ? rot(round_cd, 1'b0, sh(4'd15 - round_idx))
                                  : rot(round_cd, 1'b1, sh(round_idx + 4'd1));
      end
      if (state == PASS_END && pass_idx != 2'd2) begin
        pass_idx     <= pass_n;
        pass_decrypt <= dec_n;
        round_idx    <= '0;
        round_cd     <= dec_n ? key_n : rot(key_n, 1'b1, 2'd1);
      end
    end
  end
endmodule

// File: tb/tb_tdes_key_sequencer.sv
// tb_tdes_key_sequencer: scoreboard bench for the triple-DES key sequencer.
module tb_tdes_key_sequencer;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [55:0] key1 = '0, key2 = '0;
  logic key_load = 1'b0, start = 1'b0, mode = 1'b0;
  logic in_ready, core_init, round_en, pass_decrypt, pass_end, done, busy;
  logic [55:0] round_cd;
  logic [3:0] round_idx;
  logic [1:0] pass_idx;
  tdes_key_sequencer dut (
    .clk(clk), .rst_n(rst_n), .key1(key1), .key2(key2), .key_load(key_load),
    .start(start), .mode(mode), .in_ready(in_ready), .core_init(core_init),
    .round_en(round_en), .round_cd(round_cd), .round_idx(round_idx),
    .pass_idx(pass_idx), .pass_decrypt(pass_decrypt), .pass_end(pass_end),
    .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {int kind; int cyc; logic [55:0] cd; int ridx; int pidx; logic pdec;} ev_t;
  ev_t q[$];
  int cyc = 0, checks = 0, errors = 0, mdone = -1;
  logic [55:0] mk1 = '0, mk2 = '0;
  logic mkv = 1'b0;
  logic [55:0] seen_cd [0:63];
  logic seen_pd [0:3];
  localparam logic [55:0] KA = 56'h80000008000000, KB = 56'h12345671234567;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int cum(input int r);
    int s[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int t = 0;
    for (int i = 0; i < r; i++) t += s[i];
    return t;
  endfunction
  function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
    logic [27:0] y = '0;
    for (int i = 0; i < 28; i++) y[(i + n) % 28] = x[i];
    return y;
  endfunction
  // Decrypt round r uses the same subkey as encrypt round 17-r.
  function automatic logic [55:0] model_cd(input logic [55:0] k, input logic dec, input int r);
    int n = cum(dec ? 17 - r : r) % 28;
    return {rotl(k[55:28], n), rotl(k[27:0], n)};
  endfunction
  task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic chk_zero();
    chk("reset_outputs", {in_ready, core_init, round_en, pass_end, done, busy, round_idx, pass_idx, pass_decrypt, round_cd[44:0]}, '0);
    chk("reset_cd", round_cd, '0);
  endtask
  always @(negedge clk) begin
    int dk;
    ev_t e;
    if (rst_n) begin
      dk = core_init ? 0 : round_en ? 1 : pass_end ? 2 : done ? 3 : -1;
      if (round_en) begin
        seen_cd[int'(pass_idx) * 16 + int'(round_idx)] = round_cd;
        seen_pd[pass_idx] = pass_decrypt;
      end
      if (dk >= 0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind %0d at cyc %0d, expected no event", dk, cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != dk || e.cyc != cyc || (dk == 1 && (round_cd !== e.cd || int'(round_idx) != e.ridx
              || int'(pass_idx) != e.pidx || pass_decrypt !== e.pdec))) begin
            errors++;
            $display("FAIL event: got kind %0d cyc %0d cd %h r %0d p %0d dec %b, expected kind %0d cyc %0d cd %h r %0d p %0d dec %b",
                     dk, cyc, round_cd, round_idx, pass_idx, pass_decrypt, e.kind, e.cyc, e.cd, e.ridx, e.pidx, e.pdec);
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: got none at cyc %0d, expected kind %0d", cyc, q[0].kind);
        void'(q.pop_front());
      end
    end
  end
  task automatic drive(input logic kl, input logic st, input logic md, input logic [55:0] a, input logic [55:0] b);
    logic idle;
    int c0;
    @(negedge clk);
    #2;
    idle = cyc > mdone;
    chk("busy", {55'd0, busy}, {55'd0, !idle});
    chk("in_ready", {55'd0, in_ready}, {55'd0, idle && mkv});
    key1 = a; key2 = b; key_load = kl; start = st; mode = md;
    if (idle && kl) begin
      mk1 = a; mk2 = b; mkv = 1'b1;
    end else if (idle && st && mkv) begin
      c0 = cyc + 1;
      q.push_back('{0, c0, '0, 0, 0, 1'b0});
      for (int p = 0; p < 3; p++) begin
        for (int r = 1; r <= 16; r++)
          q.push_back('{1, c0 + p * 17 + r, model_cd(p == 1 ? mk2 : mk1, md ^ (p == 1), r), r - 1, p, md ^ (p == 1)});
        q.push_back('{2, c0 + 17 + p * 17, '0, 0, 0, 1'b0});
      end
      q.push_back('{3, c0 + 52, '0, 0, 0, 1'b0});
      mdone = c0 + 52;
    end
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero();
    q.delete();
    mkv = 1'b0; mk1 = '0; mk2 = '0; mdone = -1;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask
  initial begin
    logic [63:0] r64a, r64b;
    #3 rst_n = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, KA, KB);
    drive(1'b1, 1'b1, 1'b0, KA, KB);
    idle_n(2);
    drive(1'b0, 1'b1, 1'b0, KA, KB);
    idle_n(10);
    drive(1'b1, 1'b1, 1'b1, 56'hFFFFFFFFFFFFFF, 56'h0F0F0F0F0F0F0F);
    idle_n(50);
    chk("enc_r1", seen_cd[0], 56'h00000010000001);
    chk("enc_r2", seen_cd[1], 56'h00000020000002);
    chk("enc_r3", seen_cd[2], 56'h00000080000008);
    chk("enc_r16", seen_cd[15], 56'h80000008000000);
    chk("enc_pass3_r16", seen_cd[47], KA);
    chk("enc_dirs", {53'd0, seen_pd[0], seen_pd[1], seen_pd[2]}, 56'd2);
    drive(1'b0, 1'b1, 1'b1, KA, KB);
    idle_n(60);
    chk("dec_r1", seen_cd[0], 56'h80000008000000);
    chk("dec_r2", seen_cd[1], 56'h40000004000000);
    chk("dec_r3", seen_cd[2], 56'h10000001000000);
    chk("dec_p1_r16", seen_cd[31], 56'h12345671234567);
    chk("dec_dirs", {53'd0, seen_pd[0], seen_pd[1], seen_pd[2]}, 56'd5);
    for (int i = 0; i < 110; i++) drive(1'b0, 1'b1, 1'b0, KA, KB);
    idle_n(60);
    drive(1'b0, 1'b1, 1'b0, KA, KB);
    idle_n(24);
    do_reset();
    idle_n(5);
    for (int i = 0; i < 600; i++) begin
      r64a = {$urandom, $urandom};
      r64b = {$urandom, $urandom};
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), r64a[55:0], r64b[55:0]);
    end
    start = 1'b0;
    key_load = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
